sm_regfile_dumper: RTL



---
 rtl/sm_regfile_dumper_if.sv | 28 ++
 rtl/sm_regfile_dumper.sv | 120 ++++++++++++
 2 files changed

// File: rtl/sm_regfile_dumper_if.sv
// Byte-stream and register-file debug read port bundle for sm_regfile_dumper.
// Ports: rf_addr/rf_data (debug read port, combinational data return),
//        out_valid/out_ready/out_data (byte stream with valid/ready handshake).
interface sm_regfile_dumper_if;
  logic [4:0]  rf_addr;
  logic [31:0] rf_data;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_data;

  // master: the dumper (drives address and byte stream)
  modport master (
    output rf_addr,
    input  rf_data,
    output out_valid,
    input  out_ready,
    output out_data
  );

  // slave: register file read port plus byte sink
  modport slave (
    input  rf_addr,
    output rf_data,
    input  out_valid,
    output out_ready,
    input  out_data
  );
endinterface

// File: rtl/sm_regfile_dumper.sv
// Purpose: reads registers FIRST_REG..LAST_REG through the debug read port and streams each as 4 bytes.
// Latency: start -> LOAD next cycle -> first byte the cycle after; 5 cycles per register at full rate.
// Backpressure: out_valid/out_data hold while !out_ready; no byte dropped or duplicated.
// Ports: clk, rst_n (sync, active-low), start, abort, busy, done,
//        bus (master): rf_addr/rf_data read port, out_valid/out_ready/out_data byte stream.
module sm_regfile_dumper #(
  parameter int unsigned FIRST_REG = 0,
  parameter int unsigned LAST_REG  = 31,
  parameter bit          MSB_FIRST = 1'b0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 abort,
  output logic                 busy,
  output logic                 done,
  sm_regfile_dumper_if.master  bus
);

  localparam logic [4:0] FIRST_A = FIRST_REG[4:0];
  localparam logic [4:0] LAST_A  = LAST_REG[4:0];

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    SEND = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t      state, state_nxt;
  logic [1:0]  cnt, cnt_nxt;
  logic [4:0]  addr, addr_nxt;
  logic [31:0] snap, snap_nxt;
  logic [1:0]  sel;
  logic        hs;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= 2'd0;
      addr  <= FIRST_A;
      snap  <= 32'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      addr  <= addr_nxt;
      snap  <= snap_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    addr_nxt  = addr;
    snap_nxt  = snap;
    busy      = 1'b0;
    done      = 1'b0;
    bus.out_valid = 1'b0;
    bus.out_data  = 8'd0;
    sel       = MSB_FIRST ? (2'd3 - cnt) : cnt;
    hs        = 1'b0;

    case (state)
      IDLE: begin
        // abort wins over a simultaneous start
        if (start && !abort) begin
          state_nxt = LOAD;
          addr_nxt  = FIRST_A;
          cnt_nxt   = 2'd0;
        end
      end
      LOAD: begin
        busy = 1'b1;
        if (abort) begin
          state_nxt = IDLE;
          addr_nxt  = FIRST_A;
          cnt_nxt   = 2'd0;
        end else begin
          // the only point where the register is sampled; later core writes don't leak in
          snap_nxt  = bus.rf_data;
          state_nxt = SEND;
        end
      end
      SEND: begin
        busy          = 1'b1;
        bus.out_valid = 1'b1;
        bus.out_data  = snap[{sel, 3'b000} +: 8];
        hs            = bus.out_ready;
        if (abort) begin
          // a byte accepted this cycle is simply the last one delivered
          state_nxt = IDLE;
          addr_nxt  = FIRST_A;
          cnt_nxt   = 2'd0;
        end else if (hs) begin
          if (cnt != 2'd3) begin
            cnt_nxt = cnt + 2'd1;
          end else if (addr == LAST_A) begin
            cnt_nxt   = 2'd0;
            state_nxt = DONE;
          end else begin
            cnt_nxt   = 2'd0;
            addr_nxt  = addr + 5'd1;
            state_nxt = LOAD;
          end
        end
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
        addr_nxt  = FIRST_A;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  assign bus.rf_addr = addr;

endmodule
